// File: rtl/mult_arb_pkg.sv
// Shared constants, response entry layout and ID-width helper for the multiplier arbiter.
package mult_arb_pkg;

    localparam int MULT_W   = 16;
    localparam int MULT_PW  = 32;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [MULT_PW-1:0]  product;
        logic [ID_MAX_W-1:0] id;
    } rsp_entry_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_rsp_fifo.sv
// Synchronous response FIFO with a registered head word; a push into an empty FIFO
// becomes visible one cycle later (no fall-through).
module mult_rsp_fifo
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = MULT_PW + 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [DW-1:0] head_reg;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop      = pop && (count_reg != '0);
    assign rd_ptr_next = do_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The head register pre-reads the next head; it bypasses the array when that
    // slot is the one being written this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + CW'(push) - CW'(do_pop);
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one external approximate multiplier among NREQ requesters,
// returning tagged products in issue order. Define MULT_ARB_PERF_CNT_EN for perf counters.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  W     = MULT_W,
    parameter int  LAT   = 1,
    parameter int  DEPTH = 4,
    localparam int IDW   = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_p,
    output logic [IDW-1:0]    rsp_id
`ifdef MULT_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IFW = $clog2(LAT + 2);
    localparam int DW  = 2 * W + IDW;

    logic [W-1:0]   op_x [NREQ];
    logic [W-1:0]   op_y [NREQ];
    logic [IDW-1:0] rr_reg;
    logic [IDW-1:0] winner;
    logic           found;
    logic           credit_ok;
    logic           fire;
    logic [W-1:0]   mul_x_reg;
    logic [W-1:0]   mul_y_reg;
    logic [LAT-1:0] pipe_vld_reg;
    logic [IDW-1:0] pipe_id_reg [LAT];
    logic [IFW-1:0] inflight_reg;
    logic [CW-1:0]  fifo_count;
    logic [DW-1:0]  fifo_head;
    logic           tail_valid;
    logic           pop;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign op_x[gi]      = req_x[gi*W +: W];
        assign op_y[gi]      = req_y[gi*W +: W];
        assign req_ready[gi] = fire && (winner == IDW'(gi));
    end

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Pops in the current cycle are deliberately not credited back until they land.
    assign credit_ok = (int'(fifo_count) + int'(inflight_reg)) < DEPTH;
    assign fire      = !rst && found && credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg    <= '0;
            mul_x_reg <= '0;
            mul_y_reg <= '0;
        end else if (fire) begin
            rr_reg    <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            mul_x_reg <= op_x[winner];
            mul_y_reg <= op_y[winner];
        end
    end

    // The operand register counts as the first multiplier stage, so the tail of
    // this LAT-deep pipe lines up with a valid mul_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_reg <= '0;
            for (int s = 0; s < LAT; s++) begin
                pipe_id_reg[s] <= '0;
            end
        end else begin
            pipe_vld_reg[0] <= fire;
            pipe_id_reg[0]  <= winner;
            for (int s = 1; s < LAT; s++) begin
                pipe_vld_reg[s] <= pipe_vld_reg[s-1];
                pipe_id_reg[s]  <= pipe_id_reg[s-1];
            end
        end
    end

    assign tail_valid = pipe_vld_reg[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_reg + IFW'(fire) - IFW'(tail_valid);
        end
    end

    assign pop = rsp_valid && rsp_ready;

    mult_rsp_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tail_valid),
        .push_data ({mul_p, pipe_id_reg[LAT-1]}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assert property (@(posedge clk) disable iff (rst) !(tail_valid && (fifo_count == CW'(DEPTH))));

    assign mul_x     = mul_x_reg;
    assign mul_y     = mul_y_reg;
    assign rsp_valid = !rst && (fifo_count != '0);
    assign rsp_p     = rst ? '0 : fifo_head[DW-1:IDW];
    assign rsp_id    = rst ? '0 : fifo_head[IDW-1:0];

`ifdef MULT_ARB_PERF_CNT_EN
    logic [31:0] issue_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (fire && (issue_cnt_reg != '1)) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
            if ((|req_valid) && !credit_ok && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
